// File: rtl/sp_pkg.sv
// Shared constants and state encoding for the serial-to-parallel receiver.
package sp_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StAlign  = 2'd1,
    StActive = 2'd2
  } sp_state_e;

endpackage

// File: rtl/sp_shift_window.sv
// Serial shift register exposing the byte that completes on the current edge
// and whether that byte is the comma character.
module sp_shift_window
  import sp_pkg::*;
#(
  parameter logic [BYTE_W-1:0] Comma = COMMA_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              data_i,
  output logic [BYTE_W-1:0] window_o,
  output logic              is_comma_o
);

  logic [BYTE_W-1:0] shift_q;
  logic [BYTE_W-1:0] shift_d;

  // The window includes the bit being sampled on this edge.
  always_comb begin
    window_o   = {shift_q[BYTE_W-2:0], data_i};
    is_comma_o = (window_o == Comma);
    shift_d    = window_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/serialtoparallel_sync.sv
// Comma-aligned serial-to-parallel receiver: searches for the comma, locks after
// LOCK_COUNT aligned commas, then emits one byte per 8 bit clocks.
module serialtoparallel_sync
  import sp_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_DEFAULT,
  parameter int unsigned       LOCK_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_strobe,
  output logic              active
);

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

  logic [BYTE_W-1:0] window;
  logic              is_comma;

  sp_shift_window #(
    .Comma (COMMA)
  ) u_window (
    .clk_i      (clk_32f),
    .rst_i      (reset),
    .data_i     (data_in),
    .window_o   (window),
    .is_comma_o (is_comma)
  );

  sp_state_e         state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [3:0]        comma_cnt_q;
  logic [BYTE_W-1:0] data_q;
  logic              valid_q;
  logic              strobe_q;
  logic              active_q;

  logic       boundary;
  logic [3:0] comma_inc;

  always_comb begin
    boundary  = (bit_cnt_q == CNT_W'(7));
    comma_inc = comma_cnt_q + 4'd1;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= StSearch;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      strobe_q  <= 1'b0;
      unique case (state_q)
        StSearch: begin
          // A comma anywhere fixes the phase: next boundary is 8 edges later.
          if (is_comma) begin
            bit_cnt_q   <= '0;
            comma_cnt_q <= 4'd1;
            if (LockCnt == 4'd1) begin
              state_q  <= StActive;
              active_q <= 1'b1;
            end else begin
              state_q <= StAlign;
            end
          end
        end
        StAlign: begin
          if (boundary) begin
            if (is_comma) begin
              if (comma_inc >= LockCnt) begin
                comma_cnt_q <= LockCnt;
                state_q     <= StActive;
                active_q    <= 1'b1;
              end else begin
                comma_cnt_q <= comma_inc;
              end
            end else begin
              state_q     <= StSearch;
              comma_cnt_q <= '0;
            end
          end
        end
        StActive: begin
          if (boundary) begin
            data_q   <= window;
            valid_q  <= !is_comma;
            strobe_q <= 1'b1;
          end
        end
        default: state_q <= StSearch;
      endcase
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_serialtoparallel_sync.sv
// Scoreboard bench for serialtoparallel_sync: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every byte_strobe.
module tb_serialtoparallel_sync;
  import sp_pkg::*;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  serialtoparallel_sync #(
    .COMMA      (8'hBC),
    .LOCK_COUNT (4)
  ) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Shift one byte MSB first; optionally record the byte the receiver must emit.
  task automatic send_byte(input logic [7:0] b, input bit expect_out);
    exp_t e;
    if (expect_out) begin
      e.data  = b;
      e.valid = (b != 8'hBC);
      exp_q.push_back(e);
    end
    for (int i = 7; i >= 0; i--) begin
      data_in = b[i];
      @(posedge clk_32f);
      #1;
    end
  endtask

  task automatic reset_dut(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      data_in = ~data_in;
      @(posedge clk_32f);
      #1;
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_valid_out", 32'(valid_out), 32'h0);
      check("rst_byte_strobe", 32'(byte_strobe), 32'h0);
      check("rst_active", 32'(active), 32'h0);
      check("rst_state", 32'(dut.state_q), 32'(StSearch));
    end
    reset = 1'b0;
  endtask

  // Monitor: compares each strobed byte and the strobe spacing.
  int cyc;
  int last_strobe;
  bit have_prev;
  bit prev_strobe;

  initial begin
    cyc = 0;
    have_prev = 1'b0;
    prev_strobe = 1'b0;
    forever begin
      exp_t e;
      @(negedge clk_32f);
      cyc++;
      if (reset || !active) have_prev = 1'b0;
      if (byte_strobe) begin
        check("strobe_back_to_back", 32'(prev_strobe), 32'h0);
        if (have_prev) check("strobe_spacing", 32'(cyc - last_strobe), 32'd8);
        last_strobe = cyc;
        have_prev = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got data 0x%0h valid %0b, expected no strobe at %0t",
                   data_out, valid_out, $time);
        end else begin
          e = exp_q.pop_front();
          check("data_out", 32'(data_out), 32'(e.data));
          check("valid_out", 32'(valid_out), 32'(e.valid));
        end
      end
      prev_strobe = byte_strobe;
    end
  end

  initial begin
    logic [7:0] partial;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    data_in  = 1'b0;

    // 1: reset with toggling data
    reset_dut(3);

    // 2: three stray bits, four commas, then data
    for (int i = 0; i < 3; i++) begin
      data_in = (i != 1);
      @(posedge clk_32f);
      #1;
    end
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hBC, 1'b0);
      if (i == 2) check("no_lock_after_3", 32'(active), 32'h0);
    end
    check("lock_after_4", 32'(active), 32'h1);
    check("no_strobe_on_lock", 32'(byte_strobe), 32'h0);
    send_byte(8'hA5, 1'b1);

    // 3: comma while active is flagged invalid; data bytes back to back
    send_byte(8'hBC, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);

    // 5: reset four bits into a byte while active
    partial = 8'h55;
    for (int i = 7; i >= 4; i--) begin
      data_in = partial[i];
      @(posedge clk_32f);
      #1;
    end
    reset = 1'b1;
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
    check("midrst_active", 32'(active), 32'h0);
    check("midrst_strobe", 32'(byte_strobe), 32'h0);
    check("midrst_valid", 32'(valid_out), 32'h0);
    check("midrst_data", 32'(data_out), 32'h0);
    send_byte(8'hBC, 1'b0);
    send_byte(8'hBC, 1'b0);
    send_byte(8'h77, 1'b0);
    check("relock_needed", 32'(active), 32'h0);

    // 4: a short comma run falls back to search, a full run locks
    for (int i = 0; i < 3; i++) send_byte(8'hBC, 1'b0);
    send_byte(8'h12, 1'b0);
    check("short_run_no_lock", 32'(active), 32'h0);
    check("short_run_search", 32'(dut.state_q), 32'(StSearch));
    for (int i = 0; i < 4; i++) send_byte(8'hBC, 1'b0);
    check("second_run_lock", 32'(active), 32'h1);
    send_byte(8'h34, 1'b1);

    // 6: serializer-style stream: six idle commas then 0x01..0x08
    reset_dut(2);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'hBC, i >= 4);
      if (i == 3) check("stream_lock", 32'(active), 32'h1);
    end
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);

    @(negedge clk_32f);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
